// File: rtl/imem_pkg.sv
// imem_pkg: shared defaults and dump FSM encoding for the instruction-memory access controller
package imem_pkg;
    localparam int DATA_W       = 32;
    localparam int DEPTH_WORDS  = 128;
    localparam int CNT_W        = 8;
    localparam int STARVE_LIMIT = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} dump_state_e;
endpackage

// File: rtl/imem_dump_engine.sv
// imem_dump_engine: block-dump FSM walking word addresses at +4 strides with wrap at memory size
module imem_dump_engine #(
    parameter int CNT_W       = imem_pkg::CNT_W,
    parameter int DEPTH_WORDS = imem_pkg::DEPTH_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      base_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             gnt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      addr_o,
    output logic [CNT_W-1:0] idx_o
);
    import imem_pkg::*;
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
    dump_state_e      state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [CNT_W-1:0] count_q, count_d, idx_q, idx_d;
    logic             last;
    assign last = idx_q == count_q - CNT_W'(1);
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        if (state_q == IDLE && start_i) begin
            base_d  = base_i & ~32'd3;
            count_d = count_i;
            idx_d   = '0;
            state_d = (count_i == '0) ? DONE : RUN;
        end else if (state_q == RUN && gnt_i) begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = last ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end
    assign busy_o = state_q == RUN;
    assign done_o = state_q == DONE;
    assign addr_o = (base_q + 32'({idx_q, 2'b00})) % SPAN;
    assign idx_o  = idx_q;
endmodule

// File: rtl/imem_access_controller.sv
// imem_access_controller: arbitrates the instruction-memory read port between fetch and dump engine
module imem_access_controller #(
    parameter int DATA_W       = imem_pkg::DATA_W,
    parameter int DEPTH_WORDS  = imem_pkg::DEPTH_WORDS,
    parameter int CNT_W        = imem_pkg::CNT_W,
    parameter int STARVE_LIMIT = imem_pkg::STARVE_LIMIT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FetchReq,
    input  logic [31:0]       FetchAddr,
    output logic              FetchGnt,
    output logic              FetchValid,
    output logic [DATA_W-1:0] FetchInstr,
    input  logic              DumpStart,
    input  logic [31:0]       DumpBase,
    input  logic [CNT_W-1:0]  DumpCount,
    output logic              DumpBusy,
    output logic              DumpValid,
    output logic [CNT_W-1:0]  DumpIndex,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpDone,
    output logic [31:0]       MemAddress,
    input  logic [DATA_W-1:0] MemInstruction
);
    import imem_pkg::*;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0]     starve_q, starve_d;
    logic [31:0]       mem_addr_q, dump_addr;
    logic [CNT_W-1:0]  dump_idx, dump_index_q;
    logic [DATA_W-1:0] fetch_instr_q, dump_data_q;
    logic              fetch_valid_q, dump_valid_q, dump_gnt;
    imem_dump_engine #(.CNT_W(CNT_W), .DEPTH_WORDS(DEPTH_WORDS)) u_dump (
        .clk    (Clk),
        .rst    (Reset),
        .start_i(DumpStart),
        .base_i (DumpBase),
        .count_i(DumpCount),
        .gnt_i  (dump_gnt),
        .busy_o (DumpBusy),
        .done_o (DumpDone),
        .addr_o (dump_addr),
        .idx_o  (dump_idx)
    );
    assign FetchGnt   = FetchReq && !(DumpBusy && starve_q == SW'(STARVE_LIMIT));
    assign dump_gnt   = DumpBusy && !FetchGnt;
    assign starve_d   = (DumpBusy && !dump_gnt) ? starve_q + SW'(1) : '0;
    // Idle cycles replay the last address so the memory input never glitches.
    assign MemAddress = FetchGnt ? FetchAddr : dump_gnt ? dump_addr : mem_addr_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_q      <= '0;
            mem_addr_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            dump_valid_q  <= 1'b0;
            dump_data_q   <= '0;
            dump_index_q  <= '0;
        end else begin
            starve_q      <= starve_d;
            mem_addr_q    <= MemAddress;
            fetch_valid_q <= FetchGnt;
            dump_valid_q  <= dump_gnt;
            if (FetchGnt) fetch_instr_q <= MemInstruction;
            if (dump_gnt) begin
                dump_data_q  <= MemInstruction;
                dump_index_q <= dump_idx;
            end
        end
    end
    assign FetchValid = fetch_valid_q;
    assign FetchInstr = fetch_instr_q;
    assign DumpValid  = dump_valid_q;
    assign DumpData   = dump_data_q;
    assign DumpIndex  = dump_index_q;
endmodule
